// File: rtl/ysyx_23060191_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060191_div_seq
// Brief   : Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_23060191_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  input  logic [WIDTH-1:0] i_div_in1,
  input  logic [WIDTH-1:0] i_div_in2,
  input  logic             i_div_signed,
  input  logic             i_div_rem_sel,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_div_res
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd, dvs, rem, spec_res, res;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, rem_sel, special;

  logic             accept;
  logic             in1_neg, in2_neg, div_zero, overflow;
  logic [WIDTH-1:0] abs_in1, abs_in2;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_dvd, q_fix, r_fix, final_res;

  assign o_div_ready = (state == IDLE) && !i_flush;
  assign o_res_valid = (state == DONE);
  assign o_div_res   = res;
  assign accept      = i_div_valid && o_div_ready;

  assign in1_neg  = i_div_signed && i_div_in1[WIDTH-1];
  assign in2_neg  = i_div_signed && i_div_in2[WIDTH-1];
  assign abs_in1  = in1_neg ? -i_div_in1 : i_div_in1;
  assign abs_in2  = in2_neg ? -i_div_in2 : i_div_in2;
  assign div_zero = (i_div_in2 == '0);
  assign overflow = i_div_signed && (i_div_in1 == MIN_INT) && (i_div_in2 == '1);

  // One restoring step; the extra top bit makes the borrow the compare result.
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign ge       = !diff[WIDTH];
  assign step_rem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign step_dvd = {dvd[WIDTH-2:0], ge};

  assign q_fix     = neg_q ? -step_dvd : step_dvd;
  assign r_fix     = neg_r ? -step_rem : step_rem;
  assign final_res = special ? spec_res : (rem_sel ? r_fix : q_fix);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = CALC;
        CALC:    if (cnt == LAST) state_nxt = DONE;
        DONE:    if (i_res_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Special cases spend a single CALC cycle (counter preset to LAST) so they
  // surface one cycle after acceptance with the precomputed result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      spec_res <= '0;
      res      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      special  <= 1'b0;
    end else if (!i_flush) begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd      <= abs_in1;
            dvs      <= abs_in2;
            rem      <= '0;
            neg_q    <= in1_neg ^ in2_neg;
            neg_r    <= in1_neg;
            rem_sel  <= i_div_rem_sel;
            special  <= div_zero || overflow;
            cnt      <= (div_zero || overflow) ? LAST : '0;
            if (div_zero) spec_res <= i_div_rem_sel ? i_div_in1 : '1;
            else          spec_res <= i_div_rem_sel ? '0 : MIN_INT;
          end
        end
        CALC: begin
          dvd <= step_dvd;
          rem <= step_rem;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) res <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060191_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_23060191_div_seq
// Brief   : Scoreboard bench for the sequential divider
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_23060191_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, flush, div_valid, div_ready, div_signed, rem_sel, res_valid, res_ready;
  logic [W-1:0] in1, in2, res;

  ysyx_23060191_div_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_div_valid(div_valid), .o_div_ready(div_ready),
    .i_div_in1(in1), .i_div_in2(in2),
    .i_div_signed(div_signed), .i_div_rem_sel(rem_sel),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_div_res(res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  bit   hold = 1'b0, bp = 1'b0, have_cur = 1'b0, prev_valid = 1'b0;
  exp_t cur;
  logic [W-1:0] held;
  int   hs_edge = 0, last_acc = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  // Reference: RISC-V division semantics stated directly.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit s, input bit r);
    int sa, sb_;
    if (b == 0) return r ? a : '1;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
      sa  = a;
      sb_ = b;
      return r ? W'(sa % sb_) : W'(sa / sb_);
    end
    return r ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    if (b == 0) return 1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    res_ready = hold ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: pops the scoreboard when a result appears, checks latency,
  // stability while stalled and the value at handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (res_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", W'(res_valid), 0);
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          held     = res;
          check("latency", W'(cyc - cur.acc), W'(cur.lat));
        end
      end else if (res_valid) begin
        check("hold_stable", res, held);
      end
      if (res_valid && res_ready && have_cur) begin
        check("result", res, cur.res);
        hs_edge  = cyc + 1;
        have_cur = 1'b0;
      end
      prev_valid = res_valid && !res_ready;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s, input bit r, input bit push);
    int t = 0;
    @(negedge clk);
    while (!div_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!div_ready) begin
      check("req_timeout", W'(div_ready), 1);
      return;
    end
    div_valid  = 1'b1;
    in1        = a;
    in2        = b;
    div_signed = s;
    rem_sel    = r;
    last_acc   = cyc + 1;
    if (push) sb.push_back('{model(a, b, s, r), exp_lat(a, b, s), cyc + 1});
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    in1        = $urandom;
    in2        = $urandom;
    div_signed = 1'($urandom_range(0, 1));
    rem_sel    = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || have_cur) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("drain_timeout", W'(sb.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; in1 = '0; in2 = '0;
    div_signed = 1'b0; rem_sel = 1'b0; res_ready = 1'b1;
    #1;
    check("reset_ready", W'(div_ready), 1);
    check("reset_valid", W'(res_valid), 0);
    check("reset_res", res, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    issue(32'd100, 32'd7, 0, 0, 1);
    issue(32'd100, 32'd7, 0, 1, 1);
    issue(-32'sd7, 32'd2, 1, 0, 1);
    issue(-32'sd7, 32'd2, 1, 1, 1);
    issue(32'd7, -32'sd2, 1, 1, 1);
    issue(32'd5, 32'd0, 1, 0, 1);
    issue(32'h1234, 32'd0, 1, 1, 1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1);
    drain();

    // Back-pressure: result must hold while the consumer stalls
    hold = 1'b1;
    issue(32'd100, 32'd7, 0, 1, 1);
    begin
      int t = 0;
      while (!res_valid && t < 60) begin
        @(negedge clk);
        t++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      check("ready_in_done", W'(div_ready), 0);
    end
    hold = 1'b0;
    issue(32'd50, 32'd5, 0, 0, 1);
    check("b2b_accept", W'(last_acc - hs_edge), 1);
    drain();

    // Flush mid-calculation
    issue(32'hFFFF_FFFF, 32'd3, 0, 0, 0);
    repeat (15) @(negedge clk);
    flush = 1'b1; div_valid = 1'b1; in1 = 32'd8; in2 = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; div_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", W'(res_valid), 0);
    check("flush_ready", W'(div_ready), 1);
    // A request alongside a flush in IDLE is dropped
    flush = 1'b1; div_valid = 1'b1; in1 = 32'd6; in2 = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; div_valid = 1'b0;
    @(negedge clk);
    check("flush_req_dropped", W'(div_ready), 1);
    issue(32'd9, 32'd3, 0, 0, 1);
    drain();

    // Asynchronous reset mid-calculation
    issue(32'd100, 32'd7, 0, 0, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", W'(res_valid), 0);
    check("async_rst_ready", W'(div_ready), 1);
    check("async_rst_res", res, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized operands with random consumer back-pressure
    bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
    drain();
    bp = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
